// File: rtl/macguffin_round_engine.sv
// Iterative MacGuffin round engine: 64-bit state in four 16-bit words, one round per clock.
// Optional feature macro: MACGUFFIN_DECRYPT_EN adds the in_decrypt port and reverse rounds.
module macguffin_round_engine #(
    parameter int ROUNDS = 32,
    parameter int KIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_block,
`ifdef MACGUFFIN_DECRYPT_EN
    input  logic              in_decrypt,
`endif
    output logic [KIDX_W-1:0] rk_idx,
    input  logic [47:0]       rk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_block,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [KIDX_W-1:0] ZERO_IDX = KIDX_W'(0);
    localparam logic [KIDX_W-1:0] ONE_IDX  = KIDX_W'(1);
    localparam logic [KIDX_W-1:0] LAST_IDX = KIDX_W'(ROUNDS - 1);

    // Bit selection: per S-box, six bit numbers (two from a, two from b, two from c), S1 first.
    localparam logic [191:0] SEL_TBL =
        192'h2569BD_147A8E_368D0F_CE124A_0A3E6C_78CF15_9F5B27_BD0439;

    // MacGuffin S-boxes are the DES S-boxes reduced to their outer output bits.
    // Nibble order from the MSB: S1..S8, rows 0..3, columns 0..15.
    localparam logic [2047:0] SBOX_TBL = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC9035B6
    };

    function automatic logic [1:0] sbox(input logic [2:0] box, input logic [5:0] idx);
        logic [8:0]  pos;
        logic [10:0] hi;
        logic [3:0]  nib;
        pos = {box, idx[5], idx[0], idx[4:1]};
        hi  = 11'd2047 - {pos, 2'b00};
        nib = SBOX_TBL[hi -: 4];
        return {nib[3], nib[0]};
    endfunction

    function automatic logic [15:0] round_f(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
        logic [15:0] f;
        logic [5:0]  idx;
        logic [3:0]  bsel;
        logic [7:0]  base;
        f = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            idx = 6'd0;
            for (int k = 0; k < 6; k++) begin
                base = 8'd191 - 8'(24 * i + 4 * k);
                bsel = SEL_TBL[base -: 4];
                if (k < 2) begin
                    idx[k] = a[bsel];
                end else if (k < 4) begin
                    idx[k] = b[bsel];
                end else begin
                    idx[k] = c[bsel];
                end
            end
            f[2*i +: 2] = sbox(3'(i), idx);
        end
        return f;
    endfunction

    logic [1:0]        state_r;
    logic [15:0]       r0_r, r1_r, r2_r, r3_r;
    logic [KIDX_W-1:0] cnt_r;
    logic [KIDX_W-1:0] rk_idx_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic [63:0]       out_block_r;
`ifdef MACGUFFIN_DECRYPT_EN
    logic              dec_r;
`endif

    logic [15:0]       f_s;
    logic [15:0]       n0_s, n1_s, n2_s, n3_s;
    logic [KIDX_W-1:0] cnt_nxt_s;

    // One round of the datapath: F on the three keyed words, then the word rotation.
    always_comb begin
        cnt_nxt_s = cnt_r + ONE_IDX;
`ifdef MACGUFFIN_DECRYPT_EN
        if (dec_r) begin
            f_s  = round_f(r0_r ^ rk[15:0], r1_r ^ rk[31:16], r2_r ^ rk[47:32]);
            n0_s = r3_r ^ f_s;
            n1_s = r0_r;
            n2_s = r1_r;
            n3_s = r2_r;
        end else begin
            f_s  = round_f(r1_r ^ rk[15:0], r2_r ^ rk[31:16], r3_r ^ rk[47:32]);
            n0_s = r1_r;
            n1_s = r2_r;
            n2_s = r3_r;
            n3_s = r0_r ^ f_s;
        end
`else
        f_s  = round_f(r1_r ^ rk[15:0], r2_r ^ rk[31:16], r3_r ^ rk[47:32]);
        n0_s = r1_r;
        n1_s = r2_r;
        n2_s = r3_r;
        n3_s = r0_r ^ f_s;
`endif
    end

    // Control FSM, state words and the registered handshake/key-index outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            r0_r        <= 16'h0000;
            r1_r        <= 16'h0000;
            r2_r        <= 16'h0000;
            r3_r        <= 16'h0000;
            cnt_r       <= ZERO_IDX;
            rk_idx_r    <= ZERO_IDX;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_block_r <= 64'h0;
`ifdef MACGUFFIN_DECRYPT_EN
            dec_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        r0_r       <= in_block[15:0];
                        r1_r       <= in_block[31:16];
                        r2_r       <= in_block[47:32];
                        r3_r       <= in_block[63:48];
                        cnt_r      <= ZERO_IDX;
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
`ifdef MACGUFFIN_DECRYPT_EN
                        dec_r      <= in_decrypt;
                        rk_idx_r   <= in_decrypt ? LAST_IDX : ZERO_IDX;
`else
                        rk_idx_r   <= ZERO_IDX;
`endif
                    end
                end
                ST_RUN: begin
                    r0_r <= n0_s;
                    r1_r <= n1_s;
                    r2_r <= n2_s;
                    r3_r <= n3_s;
                    if (cnt_r == LAST_IDX) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        out_block_r <= {n3_s, n2_s, n1_s, n0_s};
                        rk_idx_r    <= ZERO_IDX;
                    end else begin
                        cnt_r       <= cnt_nxt_s;
`ifdef MACGUFFIN_DECRYPT_EN
                        rk_idx_r    <= dec_r ? (LAST_IDX - cnt_nxt_s) : cnt_nxt_s;
`else
                        rk_idx_r    <= cnt_nxt_s;
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                    rk_idx_r    <= ZERO_IDX;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_block = out_block_r;
    assign busy      = busy_r;
    assign rk_idx    = rk_idx_r;

endmodule

// File: tb/tb_macguffin_round_engine.sv
// Self-checking bench for macguffin_round_engine against a word-array MacGuffin model.
// Decrypt round trips are exercised when MACGUFFIN_DECRYPT_EN is defined.
module tb_macguffin_round_engine;

    localparam logic [63:0] PT = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] in_block, out_block;
    logic [4:0]  rk_idx;
    logic [47:0] rk;
`ifdef MACGUFFIN_DECRYPT_EN
    logic        in_decrypt;
`endif

    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [63:0] in_block2, out_block2;
    logic [4:0]  rk_idx2;
    logic [47:0] rk2;

    logic [47:0] key_tbl [32];
    int checks = 0;
    int errors = 0;

    int sel [8][6] = '{'{2, 5, 6, 9, 11, 13}, '{1, 4, 7, 10, 8, 14},
                       '{3, 6, 8, 13, 0, 15}, '{12, 14, 1, 2, 4, 10},
                       '{0, 10, 3, 14, 6, 12}, '{7, 8, 12, 15, 1, 5},
                       '{9, 15, 5, 11, 2, 7}, '{11, 13, 0, 4, 3, 9}};

    // DES S-box rows (S1 row0 .. S8 row3); column 0 is the leftmost hex digit.
    logic [63:0] des_row [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC9035B6};

    always #5 clk = ~clk;

    assign rk  = key_tbl[rk_idx];
    assign rk2 = 48'd0;

    macguffin_round_engine #(.ROUNDS(32), .KIDX_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block),
`ifdef MACGUFFIN_DECRYPT_EN
        .in_decrypt(in_decrypt),
`endif
        .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .busy(busy));

    macguffin_round_engine #(.ROUNDS(2), .KIDX_W(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_block(in_block2),
`ifdef MACGUFFIN_DECRYPT_EN
        .in_decrypt(1'b0),
`endif
        .rk_idx(rk_idx2), .rk(rk2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_block(out_block2), .busy(busy2));

    function automatic logic [15:0] model_f(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
        logic [15:0] w [3];
        logic [15:0] f;
        int idx, row, col, v;
        w[0] = a; w[1] = b; w[2] = c;
        f = 16'h0000;
        for (int box = 0; box < 8; box++) begin
            idx = 0;
            for (int k = 0; k < 6; k++)
                if (w[k / 2][sel[box][k]]) idx += (1 << k);
            row = 2 * ((idx >> 5) & 1) + (idx & 1);
            col = (idx >> 1) & 15;
            v = int'((des_row[box * 4 + row] >> (60 - 4 * col)) & 64'hF);
            f[2 * box + 1] = v[3];
            f[2 * box]     = v[0];
        end
        return f;
    endfunction

    function automatic logic [63:0] model(input logic [63:0] blk, input logic dec,
                                          input int rounds, input logic zero_keys);
        logic [15:0] w [4];
        logic [15:0] t;
        logic [47:0] k;
        for (int i = 0; i < 4; i++) w[i] = blk[16 * i +: 16];
        for (int r = 0; r < rounds; r++) begin
            k = zero_keys ? 48'd0 : key_tbl[dec ? rounds - 1 - r : r];
            if (!dec) begin
                t = w[0] ^ model_f(w[1] ^ k[15:0], w[2] ^ k[31:16], w[3] ^ k[47:32]);
                w = '{w[1], w[2], w[3], t};
            end else begin
                t = w[3] ^ model_f(w[0] ^ k[15:0], w[1] ^ k[31:16], w[2] ^ k[47:32]);
                w = '{t, w[0], w[1], w[2]};
            end
        end
        return {w[3], w[2], w[1], w[0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the engine idle; returns with out_valid pending.
    task automatic run_block(input logic [63:0] blk, input logic dec, output logic [63:0] res);
        logic [63:0] exp_blk;
        int lat;
        exp_blk = model(blk, dec, 32, 1'b0);
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_block = blk;
`ifdef MACGUFFIN_DECRYPT_EN
        in_decrypt = dec;
`endif
        @(posedge clk);
        @(negedge clk);
        in_block = {$urandom(), $urandom()};
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            if (lat < 32) begin
                check("rk_idx", 64'(rk_idx), 64'(dec ? 31 - lat : lat));
                check("busy_run", {63'd0, busy}, 64'd1);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 64'(lat), 64'd32);
        check("out_block", out_block, exp_blk);
        check("rk_idx_done", 64'(rk_idx), 64'd0);
        res = out_block;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", {63'd0, out_valid}, 64'd0);
        check("drain_ready", {63'd0, in_ready}, 64'd1);
        check("drain_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] ct, res, held, pend;
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = 64'h0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; in_block2 = 64'h0;
`ifdef MACGUFFIN_DECRYPT_EN
        in_decrypt = 1'b0;
`endif
        for (int i = 0; i < 32; i++) key_tbl[i] = 48'(48'h1111_2222_3333 * (i + 1));

        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_block", out_block, 64'd0);
        check("rst_rk_idx", 64'(rk_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Encrypt run with the fixed key ramp, then back-pressure in DONE.
        run_block(PT, 1'b0, ct);
        held = ct;
        pend = {$urandom(), $urandom()};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                in_valid = 1'b1;
                in_block = pend;
            end
            check("bp_block", out_block, held);
            check("bp_in_ready", {63'd0, in_ready}, 64'd1 - 64'd1);
            check("bp_valid", {63'd0, out_valid}, 64'd1);
        end
        drain();
        run_block(pend, 1'b0, res);
        drain();

`ifdef MACGUFFIN_DECRYPT_EN
        run_block(ct, 1'b1, res);
        check("round_trip", res, PT);
        drain();
`endif

        // Reset during round 17 discards the block.
        in_valid = 1'b1;
        in_block = {$urandom(), $urandom()};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_block", out_block, 64'd0);
        check("mid_rst_rk_idx", 64'(rk_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(64'hFFFF_0000_FFFF_0000, 1'b0, res);
        drain();

        // Random keys and blocks.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 32; i++) key_tbl[i] = 48'({$urandom(), $urandom()});
            pend = {$urandom(), $urandom()};
            run_block(pend, 1'b0, res);
            drain();
`ifdef MACGUFFIN_DECRYPT_EN
            run_block(res, 1'b1, ct);
            check("rand_round_trip", ct, pend);
            drain();
`endif
        end

        // Two-round build with zero keys.
        in_valid2 = 1'b1;
        in_block2 = 64'h0;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        while (out_valid2 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("r2_latency", 64'(lat), 64'd2);
        check("r2_block", out_block2, model(64'h0, 1'b0, 2, 1'b1));
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check("r2_drain", {63'd0, out_valid2}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
